// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared types and constants for the GMII receive framer.
package eth_rx_pkg;
   typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;
   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE = 8'hD5;
   localparam logic [31:0] CRC_POLY = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
   localparam int STAT_CRC = 0;
   localparam int STAT_LEN = 1;
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: one-byte step of the reflected CRC-32, LSB first.
module crc32_d8
   import eth_rx_pkg::*;
(
   input  logic [7:0]  data,
   input  logic [31:0] crc,
   output logic [31:0] crc_next
);
   always_comb begin
      crc_next = crc;
      for (int i = 0; i < 8; i++)
         crc_next = {1'b0, crc_next[31:1]} ^ ((crc_next[0] ^ data[i]) ? CRC_POLY : 32'h0);
   end
endmodule

// File: rtl/gmii_rx_frame.sv
// gmii_rx_frame: GMII receive framer; strips preamble/SFD and FCS, checks CRC and length.
module gmii_rx_frame
   import eth_rx_pkg::*;
#(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518,
   parameter int MAX_PRE = 7
) (
   input  logic        gmii_rx_clk,
   input  logic        rst,
   input  logic        gmii_rx_dv,
   input  logic [7:0]  gmii_rxd,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_sop,
   output logic        rx_eop,
   output logic        rx_err,
   output logic [1:0]  rx_stat,
   output logic [15:0] good_cnt,
   output logic [15:0] bad_cnt
);
   localparam logic [11:0] MIN_L = 12'(MIN_LEN);
   localparam logic [11:0] MAX_L = 12'(MAX_LEN);
   localparam logic [3:0] PRE_MAX = 4'(MAX_PRE);
   localparam logic [11:0] HOLD = 12'd5;
   state_t state, state_nx;
   logic [3:0] pre_cnt;
   logic [11:0] len;
   logic [31:0] crc, crc_nx;
   logic [4:0][7:0] dl;
   logic is_pre, is_sfd, data_byte, eof;
   logic beat_d, sop_d, eop_d, good_inc, bad_inc;
   logic [1:0] stat_d;
   assign is_pre = gmii_rxd == PREAMBLE_BYTE;
   assign is_sfd = gmii_rxd == SFD_BYTE;
   assign data_byte = state == DATA && gmii_rx_dv;
   assign eof = state == DATA && !gmii_rx_dv;
   crc32_d8 u_crc (.data(gmii_rxd), .crc(crc), .crc_next(crc_nx));
   always_ff @(posedge gmii_rx_clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (gmii_rx_dv) state_nx = is_pre ? PRE : is_sfd ? DATA : DROP;
         PRE: state_nx = !gmii_rx_dv ? IDLE : is_sfd ? DATA :
                         (is_pre && pre_cnt < PRE_MAX) ? PRE : DROP;
         default: if (!gmii_rx_dv) state_nx = IDLE;
      endcase
   end
   // Five bytes are held back so the four FCS bytes never reach the output.
   always_comb begin
      stat_d = '0;
      stat_d[STAT_CRC] = crc != CRC_RESIDUE;
      stat_d[STAT_LEN] = len < MIN_L || len > MAX_L;
      beat_d = state == DATA && len >= HOLD;
      sop_d = beat_d && len == HOLD;
      eop_d = beat_d && !gmii_rx_dv;
      good_inc = eop_d && stat_d == 2'b00;
      bad_inc = eof && (len < HOLD || stat_d != 2'b00);
   end
   always_ff @(posedge gmii_rx_clk or posedge rst)
      if (rst) begin
         pre_cnt <= '0;
         len <= '0;
         crc <= CRC_INIT;
         dl <= '0;
         rx_data <= '0;
         rx_valid <= 1'b0;
         rx_sop <= 1'b0;
         rx_eop <= 1'b0;
         rx_err <= 1'b0;
         rx_stat <= '0;
         good_cnt <= '0;
         bad_cnt <= '0;
      end else begin
         pre_cnt <= state == PRE ? pre_cnt + 4'd1 : 4'd1;
         len <= data_byte ? len + {11'd0, len != 12'hFFF} : '0;
         crc <= data_byte ? crc_nx : CRC_INIT;
         if (data_byte) dl <= {dl[3:0], gmii_rxd};
         rx_data <= dl[4];
         rx_valid <= beat_d;
         rx_sop <= sop_d;
         rx_eop <= eop_d;
         rx_err <= eop_d && stat_d != 2'b00;
         rx_stat <= eop_d ? stat_d : 2'b00;
         good_cnt <= good_cnt + {15'd0, good_inc};
         bad_cnt <= bad_cnt + {15'd0, bad_inc};
      end
endmodule

// File: tb/tb_gmii_rx_frame.sv
// tb_gmii_rx_frame: scoreboard bench for the GMII receive framer.
module tb_gmii_rx_frame;
   logic clk = 0, rst = 1, dv = 0;
   logic [7:0] rxd = 8'h00;
   logic [7:0] rx_data;
   logic rx_valid, rx_sop, rx_eop, rx_err;
   logic [1:0] rx_stat;
   logic [15:0] good_cnt, bad_cnt;
   typedef struct packed {logic [7:0] d; logic sop, eop, err; logic [1:0] stat;} beat_t;
   typedef struct {int n_pay; bit bad; int dg; int db;} vec_t;
   beat_t sb[$];
   beat_t act, expv;
   vec_t vt[8];
   int n_chk = 0, n_pass = 0, exp_good = 0, exp_bad = 0;
   logic [7:0] q[$], q2[$];

   gmii_rx_frame dut (
      .gmii_rx_clk(clk), .rst(rst), .gmii_rx_dv(dv), .gmii_rxd(rxd),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop), .rx_eop(rx_eop),
      .rx_err(rx_err), .rx_stat(rx_stat), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
   );

   always #4 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, a, e);
   endtask

   always @(negedge clk)
      if (!rst && rx_valid) begin
         act = {rx_data, rx_sop, rx_eop, rx_eop & rx_err, rx_eop ? rx_stat : 2'b00};
         if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_beat: got %0h want none", act);
         end else begin
            expv = sb.pop_front();
            chk("beat", 32'(act), 32'(expv));
         end
      end

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      for (int i = 0; i < 8; i++)
         c = (c[0] ^ b[i]) ? ({1'b0, c[31:1]} ^ 32'hEDB88320) : {1'b0, c[31:1]};
      return c;
   endfunction

   task automatic build(input int n_pay, input bit bad_fcs, output logic [7:0] f[$]);
      logic [31:0] c;
      logic [1:0] st;
      logic [7:0] b;
      int n;
      c = 32'hFFFFFFFF;
      n = n_pay + 4;
      f = {};
      repeat (7) f.push_back(8'h55);
      f.push_back(8'hD5);
      st = {(n < 64 || n > 1518), bad_fcs};
      for (int i = 0; i < n_pay; i++) begin
         b = 8'($urandom_range(0, 255));
         f.push_back(b);
         c = crc_byte(c, b);
         sb.push_back({b, i == 0, i == n_pay - 1, i == n_pay - 1 && st != 2'b00,
                       i == n_pay - 1 ? st : 2'b00});
      end
      c = ~c;
      c[0] = c[0] ^ bad_fcs;
      for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
   endtask

   task automatic drive(input logic [7:0] f[$], input int gap);
      foreach (f[i]) begin
         @(negedge clk);
         dv = 1;
         rxd = f[i];
      end
      @(negedge clk);
      dv = 0;
      rxd = 8'hA5;
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic settle(input string name);
      repeat (4) @(negedge clk);
      chk({name, "_good"}, 32'(good_cnt), 32'(exp_good));
      chk({name, "_bad"}, 32'(bad_cnt), 32'(exp_bad));
      chk({name, "_drained"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      vt = '{'{60, 0, 1, 0}, '{60, 1, 0, 1}, '{16, 0, 0, 1}, '{1596, 0, 0, 1},
             '{1, 0, 0, 1}, '{1514, 0, 1, 0}, '{1515, 0, 0, 1}, '{59, 0, 0, 1}};
      repeat (3) @(negedge clk);
      chk("reset_outs", {rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_stat, 18'd0}, 32'd0);
      chk("reset_cnts", {good_cnt, bad_cnt}, 32'd0);
      rst = 0;
      repeat (2) @(negedge clk);
      foreach (vt[i]) begin
         build(vt[i].n_pay, vt[i].bad, q);
         drive(q, 3);
         exp_good += vt[i].dg;
         exp_bad += vt[i].db;
         settle($sformatf("vec%0d", i));
      end
      q = '{8'h55, 8'h55, 8'h5D, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      drive(q, 3);
      settle("bad_preamble");
      q = {};
      repeat (8) q.push_back(8'h55);
      q.push_back(8'hD5);
      repeat (10) q.push_back(8'h77);
      drive(q, 3);
      settle("long_preamble");
      q = {};
      repeat (7) q.push_back(8'h55);
      q.push_back(8'hD5);
      q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h03);
      drive(q, 3);
      exp_bad++;
      settle("short3");
      build(60, 0, q);
      repeat (7) void'(q.pop_front());
      drive(q, 3);
      exp_good++;
      settle("no_preamble");
      build(60, 0, q);
      build(60, 0, q2);
      drive(q, 1);
      drive(q2, 3);
      exp_good += 2;
      settle("back_to_back");
      build(60, 0, q);
      for (int i = 0; i < 38; i++) begin
         @(negedge clk);
         dv = 1;
         rxd = q[i];
      end
      @(negedge clk);
      rst = 1;
      dv = 0;
      #1;
      chk("midreset_outs", {rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_stat, 18'd0}, 32'd0);
      chk("midreset_cnts", {good_cnt, bad_cnt}, 32'd0);
      sb.delete();
      exp_good = 0;
      exp_bad = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      build(60, 0, q);
      drive(q, 3);
      exp_good = 1;
      settle("after_reset");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
